// File: rtl/br_pkg.sv
// Shared types and constants for the execute-stage branch resolution unit.
// Contents: funct3 encodings, FSM state enum, 2-bit BHT counter type and values,
//           and a helper that tells whether a funct3 names a real conditional branch.
package br_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } br_state_e;

    typedef logic [1:0] bht_cnt_t;

    localparam bht_cnt_t SNT = 2'b00;
    localparam bht_cnt_t WNT = 2'b01;
    localparam bht_cnt_t WT  = 2'b10;
    localparam bht_cnt_t ST  = 2'b11;

    // 010 and 011 are not branch encodings; they must never train the BHT.
    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

endpackage

// File: rtl/br_bht.sv
// Branch history table: ENTRIES saturating 2-bit counters, all reset to weakly not-taken.
// Latency: read is combinational; write lands on the next rising edge (same-cycle read sees old value).
// Backpressure: none; one read and one write per cycle always accepted.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_rd_idx/o_rd_cnt fetch lookup;
//        i_wr_en/i_wr_idx/i_wr_taken training from resolved conditional branches.
module br_bht
    import br_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [1:0]       o_rd_cnt,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);

    bht_cnt_t r_cnt [ENTRIES];

    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_cnt[g] <= WNT;
            end else if (i_wr_en && (i_wr_idx == IDX_W'(g))) begin
                if (i_wr_taken) begin
                    if (r_cnt[g] != ST) r_cnt[g] <= r_cnt[g] + 2'd1;
                end else begin
                    if (r_cnt[g] != SNT) r_cnt[g] <= r_cnt[g] - 2'd1;
                end
            end
        end
    end

    assign o_rd_cnt = r_cnt[i_rd_idx];

endmodule

// File: rtl/br_resolve.sv
// Execute-stage branch resolution: decides taken, checks the fetch prediction, redirects and flushes.
// Latency: redirect_valid/redirect_pc registered 1 cycle after EX; flush high FLUSH_CYCLES cycles.
// Backpressure: none; while flushing, EX inputs are wrong-path and ignored.
// Ports: i_clk, i_rst_n; ex_* execute-stage instruction; br_less/br_equal/br_unsigned comparator link;
//        if_pc/if_pred_taken fetch prediction; redirect_valid/redirect_pc/flush to the front end.
// Optional: define BR_RESOLVE_PERF_EN to add perf_br_cnt / perf_mis_cnt event counters.
module br_resolve
    import br_pkg::*;
#(
    parameter int BHT_ENTRIES  = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        ex_valid,
    input  logic        ex_is_br,
    input  logic        ex_is_jmp,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic        br_less,
    input  logic        br_equal,
    output logic        br_unsigned,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush
`ifdef BR_RESOLVE_PERF_EN
    ,
    output logic [31:0] perf_br_cnt,
    output logic [31:0] perf_mis_cnt
`endif
);

    localparam int         IDX_W      = $clog2(BHT_ENTRIES);
    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    br_state_e   r_state;
    br_state_e   w_state_nxt;
    logic [1:0]  r_flush_cnt;
    logic [1:0]  w_flush_cnt_nxt;
    logic        r_redir_vld;
    logic [31:0] r_redir_pc;

    logic        w_cond;
    logic        w_taken;
    logic        w_resolve;
    logic        w_mispredict;
    logic [31:0] w_correct_pc;
    logic        w_bht_upd;
    logic [1:0]  w_bht_rd;

    // Signed/unsigned compare select comes straight from funct3 bit 1 (BLTU/BGEU).
    assign br_unsigned = ex_funct3[1];

    always_comb begin
        w_cond = 1'b0;
        case (ex_funct3)
            F3_BEQ:           w_cond = br_equal;
            F3_BNE:           w_cond = ~br_equal;
            F3_BLT, F3_BLTU:  w_cond = br_less;
            F3_BGE, F3_BGEU:  w_cond = ~br_less;
            default:          w_cond = 1'b0;
        endcase
    end

    // A jump wins over a simultaneously flagged branch.
    assign w_taken      = ex_is_jmp | (ex_is_br & w_cond);
    assign w_resolve    = ex_valid & (ex_is_br | ex_is_jmp) & (r_state == IDLE);
    assign w_mispredict = w_resolve & (w_taken != ex_pred_taken);
    assign w_correct_pc = w_taken ? ex_target : (ex_pc + 32'd4);
    assign w_bht_upd    = w_resolve & ex_is_br & ~ex_is_jmp & f3_legal(ex_funct3);

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        case (r_state)
            IDLE: begin
                if (w_mispredict) begin
                    w_state_nxt     = FLUSH;
                    w_flush_cnt_nxt = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (r_flush_cnt == 2'd0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - 2'd1;
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_flush_cnt_nxt = 2'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_flush_cnt <= 2'd0;
            r_redir_vld <= 1'b0;
            r_redir_pc  <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_redir_vld <= w_mispredict;
            if (w_mispredict) r_redir_pc <= w_correct_pc;
        end
    end

    assign redirect_valid = r_redir_vld;
    assign redirect_pc    = r_redir_pc;
    // Entering FLUSH coincides with the redirect edge, so the state alone gives the flush window.
    assign flush          = (r_state == FLUSH);

    br_bht #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_rd_idx   (if_pc[IDX_W+1:2]),
        .o_rd_cnt   (w_bht_rd),
        .i_wr_en    (w_bht_upd),
        .i_wr_idx   (ex_pc[IDX_W+1:2]),
        .i_wr_taken (w_taken)
    );

    assign if_pred_taken = w_bht_rd[1];

    // Fetch PC bits outside the index and the counter LSB are intentionally not consumed.
    logic w_unused;
    assign w_unused = ^{if_pc[31:IDX_W+2], if_pc[1:0], w_bht_rd[0]};

`ifdef BR_RESOLVE_PERF_EN
    logic [31:0] r_perf_br;
    logic [31:0] r_perf_mis;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_perf_br  <= 32'd0;
            r_perf_mis <= 32'd0;
        end else begin
            if (w_resolve)    r_perf_br  <= r_perf_br + 32'd1;
            if (w_mispredict) r_perf_mis <= r_perf_mis + 32'd1;
        end
    end

    assign perf_br_cnt  = r_perf_br;
    assign perf_mis_cnt = r_perf_mis;
`endif

endmodule
